// File: rtl/axi4_lite_master_slave.sv
// AXI4-Lite subsystem: a command-holding master wired point-to-point to a
// slave that backs a 16-word register file. Only clock and reset are pins;
// master requests are written hierarchically by the environment.
//
// Handshake rule on every channel: a transfer happens on the rising ACLK edge
// where valid and ready are both 1. Ready is a property of FSM state and holds
// until its handshake. Valid need not be held past its handshake edge. All
// slave ready/valid outputs are registered, so they change only on edges.
module axi4_lite_master_slave #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic ACLK,
    input logic ARESETN
);
    localparam int STRB = DATA_WIDTH / 8;

    logic [ADDRESS-1:0]    awaddr, araddr;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic [STRB-1:0]       wstrb;
    logic                  awvalid, awready, wvalid, wready;
    logic                  bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0]            bresp, rresp;

    axi_lite_master #(.ADDRESS(ADDRESS), .DATA_WIDTH(DATA_WIDTH)) axi_master_inst (
        .aw_addr   (awaddr),
        .aw_valid  (awvalid),
        .w_data    (wdata),
        .w_strb    (wstrb),
        .w_valid   (wvalid),
        .b_ready   (bready),
        .ar_addr   (araddr),
        .ar_valid  (arvalid),
        .r_ready   (rready),
        .M_AWREADY (awready),
        .M_WREADY  (wready),
        .M_BVALID  (bvalid),
        .M_BRESP   (bresp),
        .M_ARREADY (arready),
        .M_RVALID  (rvalid),
        .M_RDATA   (rdata),
        .M_RRESP   (rresp)
    );

    axi_lite_slave #(.ADDRESS(ADDRESS), .DATA_WIDTH(DATA_WIDTH)) axi_slave_inst (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .S_AWADDR  (awaddr),
        .S_AWVALID (awvalid),
        .S_AWREADY (awready),
        .S_WDATA   (wdata),
        .S_WSTRB   (wstrb),
        .S_WVALID  (wvalid),
        .S_WREADY  (wready),
        .S_BVALID  (bvalid),
        .S_BRESP   (bresp),
        .S_BREADY  (bready),
        .S_ARADDR  (araddr),
        .S_ARVALID (arvalid),
        .S_ARREADY (arready),
        .S_RVALID  (rvalid),
        .S_RDATA   (rdata),
        .S_RRESP   (rresp),
        .S_RREADY  (rready)
    );
endmodule

// Command-holding master: request variables have no logic driver here; they
// hold whatever the environment last deposited. Responses are only observed.
module axi_lite_master #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    output logic [ADDRESS-1:0]      aw_addr,
    output logic                    aw_valid,
    output logic [DATA_WIDTH-1:0]   w_data,
    output logic [DATA_WIDTH/8-1:0] w_strb,
    output logic                    w_valid,
    output logic                    b_ready,
    output logic [ADDRESS-1:0]      ar_addr,
    output logic                    ar_valid,
    output logic                    r_ready,
    input  logic                    M_AWREADY,
    input  logic                    M_WREADY,
    input  logic                    M_BVALID,
    input  logic [1:0]              M_BRESP,
    input  logic                    M_ARREADY,
    input  logic                    M_RVALID,
    input  logic [DATA_WIDTH-1:0]   M_RDATA,
    input  logic [1:0]              M_RRESP
);
    logic [ADDRESS-1:0]      M_AWADDR  = '0;
    logic                    M_AWVALID = 1'b0;
    logic [DATA_WIDTH-1:0]   M_WDATA   = '0;
    logic [DATA_WIDTH/8-1:0] M_WSTRB   = '0;
    logic                    M_WVALID  = 1'b0;
    logic                    M_BREADY  = 1'b0;
    logic [ADDRESS-1:0]      M_ARADDR  = '0;
    logic                    M_ARVALID = 1'b0;
    logic                    M_RREADY;
    logic                    unused_resp;

    assign M_RREADY = 1'b1;
    assign aw_addr  = M_AWADDR;
    assign aw_valid = M_AWVALID;
    assign w_data   = M_WDATA;
    assign w_strb   = M_WSTRB;
    assign w_valid  = M_WVALID;
    assign b_ready  = M_BREADY;
    assign ar_addr  = M_ARADDR;
    assign ar_valid = M_ARVALID;
    assign r_ready  = M_RREADY;

    // Responses are watched from outside; fold them so they count as consumed.
    assign unused_resp = ^{M_AWREADY, M_WREADY, M_BVALID, M_BRESP,
                           M_ARREADY, M_RVALID, M_RDATA, M_RRESP};
endmodule

// Slave with independent write and read FSMs over a 16-word register file.
module axi_lite_slave #(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDRESS-1:0]      S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic                    S_BVALID,
    output logic [1:0]              S_BRESP,
    input  logic                    S_BREADY,
    input  logic [ADDRESS-1:0]      S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic                    S_RVALID,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    input  logic                    S_RREADY
);
    localparam int STRB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [3:0]            aw_idx, ar_idx;
    logic                  aw_ok, ar_ok;
    logic                  aw_hs, w_hs, ar_hs;
    logic [DATA_WIDTH-1:0] regs [16];
    logic                  unused_addr_bits;

    // Byte-lane bits of the address do not select anything.
    assign unused_addr_bits = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

    assign aw_hs = (w_state == W_IDLE) && S_AWVALID && S_AWREADY;
    assign w_hs  = (w_state == W_DATA) && S_WVALID && S_WREADY;
    assign ar_hs = (r_state == R_IDLE) && S_ARVALID && S_ARREADY;

    // Write and read state registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next state: accept address, one turnaround cycle, data, response.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_WAIT;
            W_WAIT:  w_next = W_DATA;
            W_DATA:  if (w_hs) w_next = W_RESP;
            W_RESP:  if (S_BREADY) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read next state: accept address, one register-lookup cycle, data beat.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_READ;
            R_READ:  r_next = R_DATA;
            R_DATA:  if (S_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write-side outputs registered from the next state; latch address on AW.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b0;
            S_BRESP   <= 2'b00;
            aw_idx    <= '0;
            aw_ok     <= 1'b0;
        end else begin
            S_AWREADY <= (w_next == W_IDLE);
            S_WREADY  <= (w_next == W_DATA);
            S_BVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                aw_idx <= S_AWADDR[5:2];
                aw_ok  <= (S_AWADDR[ADDRESS-1:6] == '0);
            end
            if (w_hs) S_BRESP <= aw_ok ? 2'b00 : 2'b10;
        end
    end

    // Read-side outputs; data and response are captured in R_READ and then held.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_ARREADY <= 1'b0;
            S_RVALID  <= 1'b0;
            S_RDATA   <= '0;
            S_RRESP   <= 2'b00;
            ar_idx    <= '0;
            ar_ok     <= 1'b0;
        end else begin
            S_ARREADY <= (r_next == R_IDLE);
            S_RVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                ar_idx <= S_ARADDR[5:2];
                ar_ok  <= (S_ARADDR[ADDRESS-1:6] == '0);
            end
            if (r_state == R_READ) begin
                S_RDATA <= ar_ok ? regs[ar_idx] : '0;
                S_RRESP <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end

    // Register file: cleared by reset, byte-masked update on an in-range W beat.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (w_hs && aw_ok) begin
            for (int b = 0; b < STRB; b++) begin
                if (S_WSTRB[b]) regs[aw_idx][b*8 +: 8] <= S_WDATA[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi4_lite_master_slave.sv
// Bench for the AXI4-Lite subsystem: drives master request variables
// hierarchically, watches responses at the master, and compares against a
// word-array model of the register file.
module tb_axi4_lite_master_slave;
    logic ACLK;
    logic ARESETN;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [16];

    axi4_lite_master_slave #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN)
    );

    wire        aw_ready = dut.axi_master_inst.M_AWREADY;
    wire        w_ready  = dut.axi_master_inst.M_WREADY;
    wire        b_valid  = dut.axi_master_inst.M_BVALID;
    wire [1:0]  b_resp   = dut.axi_master_inst.M_BRESP;
    wire        ar_ready = dut.axi_master_inst.M_ARREADY;
    wire        r_valid  = dut.axi_master_inst.M_RVALID;
    wire [31:0] r_data   = dut.axi_master_inst.M_RDATA;
    wire [1:0]  r_resp   = dut.axi_master_inst.M_RRESP;

    // Clock and watchdog.
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
    endfunction

    // Returns the expected BRESP and applies the write to the model.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] word;
        if (addr >= 32'h40) return 2'b10;
        word = model_mem[addr[5:2]];
        for (int b = 0; b < 4; b++)
            if (strb[b]) word[b*8 +: 8] = data[b*8 +: 8];
        model_mem[addr[5:2]] = word;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return (addr >= 32'h40) ? 32'h0 : model_mem[addr[5:2]];
    endfunction

    // Wait (bounded) at falling edges until a ready reads 1.
    task automatic wait_ready(input bit aw_not_ar, input string name);
        int n = 0;
        while (((aw_not_ar ? aw_ready : ar_ready) !== 1'b1) && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s_timeout: ready never rose within 50 cycles", name);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int wdly, input int bdly);
        logic [1:0] exp_resp;
        exp_resp = model_write(addr, data, strb);
        @(negedge ACLK);
        dut.axi_master_inst.M_AWADDR  = addr;
        dut.axi_master_inst.M_AWVALID = 1'b1;
        dut.axi_master_inst.M_WDATA   = data;
        dut.axi_master_inst.M_WSTRB   = strb;
        dut.axi_master_inst.M_WVALID  = (wdly == 0);
        wait_ready(1'b1, "awready");
        @(posedge ACLK);                  // AW handshake edge E
        @(negedge ACLK);
        dut.axi_master_inst.M_AWVALID = 1'b0;
        checks++;
        if (aw_ready !== 1'b0 || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL w_turnaround: awready=%b wready=%b required 0 0", aw_ready, w_ready);
        end
        @(negedge ACLK);                  // after E+1
        checks++;
        if (w_ready !== 1'b1) begin
            errors++;
            $display("FAIL wready_latency: wready=%b required 1 one edge after AW", w_ready);
        end
        if (wdly > 0) begin
            repeat (wdly) @(negedge ACLK);
            checks++;
            if (w_ready !== 1'b1) begin
                errors++;
                $display("FAIL wready_hold: wready=%b required 1 while WVALID low", w_ready);
            end
            dut.axi_master_inst.M_WVALID = 1'b1;
        end
        @(posedge ACLK);                  // W handshake edge
        @(negedge ACLK);
        dut.axi_master_inst.M_WVALID = 1'b0;
        checks++;
        if (b_valid !== 1'b1 || w_ready !== 1'b0 || b_resp !== exp_resp) begin
            errors++;
            $display("FAIL b_response: bvalid=%b wready=%b bresp=%b required 1 0 %b",
                     b_valid, w_ready, b_resp, exp_resp);
        end
        repeat (bdly) @(negedge ACLK);
        checks++;
        if (b_valid !== 1'b1) begin
            errors++;
            $display("FAIL bvalid_hold: bvalid=%b required 1 until BREADY", b_valid);
        end
        dut.axi_master_inst.M_BREADY = 1'b1;
        @(posedge ACLK);                  // B handshake edge
        @(negedge ACLK);
        dut.axi_master_inst.M_BREADY = 1'b0;
        checks++;
        if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL b_done: bvalid=%b awready=%b required 0 1", b_valid, aw_ready);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] got);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = model_read(addr);
        exp_resp = (addr >= 32'h40) ? 2'b10 : 2'b00;
        @(negedge ACLK);
        dut.axi_master_inst.M_ARADDR  = addr;
        dut.axi_master_inst.M_ARVALID = 1'b1;
        wait_ready(1'b0, "arready");
        @(posedge ACLK);                  // AR handshake edge E
        @(negedge ACLK);
        dut.axi_master_inst.M_ARVALID = 1'b0;
        checks++;
        if (ar_ready !== 1'b0 || r_valid !== 1'b0) begin
            errors++;
            $display("FAIL r_lookup: arready=%b rvalid=%b required 0 0", ar_ready, r_valid);
        end
        @(negedge ACLK);                  // after E+1
        got = r_data;
        checks++;
        if (r_valid !== 1'b1 || r_data !== exp_data || r_resp !== exp_resp) begin
            errors++;
            $display("FAIL r_beat addr=%h: rvalid=%b rdata=%h rresp=%b required 1 %h %b",
                     addr, r_valid, r_data, r_resp, exp_data, exp_resp);
        end
        @(negedge ACLK);                  // after E+2
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL r_done: rvalid=%b arready=%b required 0 1", r_valid, ar_ready);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        model_clear();
        #12;
        checks++;
        if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, b_resp, r_resp} !== 9'b0 || r_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: aw=%b w=%b b=%b ar=%b r=%b bresp=%b rresp=%b rdata=%h required all 0",
                     aw_ready, w_ready, b_valid, ar_ready, r_valid, b_resp, r_resp, r_data);
        end
        #8 ARESETN = 1'b1;               // release at 20 ns
        #2;
        checks++;
        if (aw_ready !== 1'b0 || ar_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: aw=%b ar=%b required 0 0", aw_ready, ar_ready);
        end
        @(negedge ACLK);
        checks++;
        if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: aw=%b ar=%b required 1 1", aw_ready, ar_ready);
        end
    endtask

    task automatic test_full_write();
        do_write(32'h10, 32'hABCD1234, 4'hF, 0, 2);
    endtask

    task automatic test_readback();
        logic [31:0] got;
        do_read(32'h10, got);
        checks++;
        if (got !== 32'hABCD1234) begin
            errors++;
            $display("FAIL readback: rdata=%h required abcd1234", got);
        end
    endtask

    task automatic test_partial_strobe();
        logic [31:0] got;
        do_write(32'h10, 32'h55667788, 4'b0011, 1, 0);
        do_read(32'h10, got);
        checks++;
        if (got !== 32'hABCD7788) begin
            errors++;
            $display("FAIL partial_strobe: rdata=%h required abcd7788", got);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] got;
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(32'h40, got);
        do_read(32'h00, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL oor_alias: read 0x00 rdata=%h required 0", got);
        end
    endtask

    // W handshake lands on the same edge as R_READ for the same word.
    task automatic test_back_to_back();
        logic [31:0] old_val, got;
        logic [1:0]  exp_resp;
        do_write(32'h24, 32'h11112222, 4'hF, 0, 0);
        old_val = model_read(32'h24);
        @(negedge ACLK);
        dut.axi_master_inst.M_AWADDR  = 32'h24;
        dut.axi_master_inst.M_AWVALID = 1'b1;
        dut.axi_master_inst.M_WDATA   = 32'hCAFEF00D;
        dut.axi_master_inst.M_WSTRB   = 4'hF;
        dut.axi_master_inst.M_WVALID  = 1'b1;
        @(posedge ACLK);                  // AW handshake E
        @(negedge ACLK);
        dut.axi_master_inst.M_AWVALID = 1'b0;
        dut.axi_master_inst.M_ARADDR  = 32'h24;
        dut.axi_master_inst.M_ARVALID = 1'b1;
        @(posedge ACLK);                  // AR handshake E+1
        @(negedge ACLK);
        dut.axi_master_inst.M_ARVALID = 1'b0;
        @(posedge ACLK);                  // W handshake and R_READ on E+2
        @(negedge ACLK);
        dut.axi_master_inst.M_WVALID = 1'b0;
        checks++;
        if (r_valid !== 1'b1 || r_data !== old_val) begin
            errors++;
            $display("FAIL same_edge_read: rvalid=%b rdata=%h required 1 %h", r_valid, r_data, old_val);
        end
        exp_resp = model_write(32'h24, 32'hCAFEF00D, 4'hF);
        checks++;
        if (b_valid !== 1'b1 || b_resp !== exp_resp) begin
            errors++;
            $display("FAIL same_edge_b: bvalid=%b bresp=%b required 1 %b", b_valid, b_resp, exp_resp);
        end
        dut.axi_master_inst.M_BREADY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        dut.axi_master_inst.M_BREADY = 1'b0;
        do_read(32'h24, got);
        checks++;
        if (got !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL b2b_newval: rdata=%h required cafef00d", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, got;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) addr = {$urandom_range(1, 1023), 6'($urandom_range(0, 63))};
            else addr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            do_write(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) addr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            do_read(addr, got);
        end
    endtask

    task automatic test_mid_write_reset();
        logic [31:0] got;
        int          seen_b = 0;
        @(negedge ACLK);
        dut.axi_master_inst.M_AWADDR  = 32'h10;
        dut.axi_master_inst.M_AWVALID = 1'b1;
        dut.axi_master_inst.M_WDATA   = 32'h12345678;
        dut.axi_master_inst.M_WSTRB   = 4'hF;
        dut.axi_master_inst.M_WVALID  = 1'b0;
        wait_ready(1'b1, "awready_mid");
        @(posedge ACLK);
        @(negedge ACLK);
        dut.axi_master_inst.M_AWVALID = 1'b0;
        @(negedge ACLK);
        checks++;
        if (w_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_wready: wready=%b required 1", w_ready);
        end
        ARESETN = 1'b0;
        dut.axi_master_inst.M_WVALID = 1'b1;
        model_clear();
        #1;
        checks++;
        if (w_ready !== 1'b0 || b_valid !== 1'b0 || aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: wready=%b bvalid=%b awready=%b required 0 0 0",
                     w_ready, b_valid, aw_ready);
        end
        repeat (2) @(negedge ACLK);
        dut.axi_master_inst.M_WVALID = 1'b0;
        ARESETN = 1'b1;
        repeat (6) begin
            @(negedge ACLK);
            if (b_valid !== 1'b0) seen_b++;
        end
        checks++;
        if (seen_b != 0 || aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL dropped_write: bvalid cycles=%0d awready=%b required 0 1", seen_b, aw_ready);
        end
        do_read(32'h10, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL cleared_regs: rdata=%h required 0", got);
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_readback();
        test_partial_strobe();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_mid_write_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
